// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with per-register pending-write counters.
// Optional REGFILE_BYPASS_EN: write-through from WB to the read ports.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int PEND_W   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    output logic              RsBusy,
    output logic              RtBusy,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueAddr,
    output logic              IssueReady,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [PEND_W-1:0] pend [NREG];

    function automatic logic isZero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        RsData = regs[RsAddr];
        RsBusy = (pend[RsAddr] != '0);
        RtData = regs[RtAddr];
        RtBusy = (pend[RtAddr] != '0);
`ifdef REGFILE_BYPASS_EN
        // The writeback this cycle retires one reservation as it forwards.
        if (RegWrite && (WriteAddr == RsAddr) && !isZero(RsAddr)) begin
            RsData = WriteData;
            RsBusy = (pend[RsAddr] > PEND_ONE);
        end
        if (RegWrite && (WriteAddr == RtAddr) && !isZero(RtAddr)) begin
            RtData = WriteData;
            RtBusy = (pend[RtAddr] > PEND_ONE);
        end
`endif
        if (isZero(RsAddr)) begin
            RsData = '0;
            RsBusy = 1'b0;
        end
        if (isZero(RtAddr)) begin
            RtData = '0;
            RtBusy = 1'b0;
        end
    end

    always_comb begin
        IssueReady = isZero(IssueAddr) || (pend[IssueAddr] != PEND_MAX);
    end

    for (genvar g = 0; g < NREG; g++) begin : gReg
        localparam bit HARD = (ZERO_REG != 0) && (g == 0);
        logic hit;
        logic inc;
        logic dec;

        always_comb begin
            hit = RegWrite && (WriteAddr == ADDR_W'(g)) && !HARD;
            inc = IssueValid && IssueReady
                  && (IssueAddr == ADDR_W'(g)) && !HARD;
            dec = hit && (pend[g] != '0);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs[g] <= '0;
                pend[g] <= '0;
            end else begin
                if (hit) begin
                    regs[g] <= WriteData;
                end
                if (inc && !dec) begin
                    pend[g] <= pend[g] + PEND_ONE;
                end else if (dec && !inc) begin
                    pend[g] <= pend[g] - PEND_ONE;
                end
            end
        end
    end

endmodule
